cluster_result_checker: RTL and testbench
=========================================

Name: cluster_result_checker

Overview:
- Downstream consumer of the learned per-bit cluster logic (the module_output_bit_* family).
- Captures the cluster output vector for each applied test, compares it against golden bits from the reference CPU model, and accumulates test and mismatch counts.
- Produces the accuracy figures quoted in each generated circuit's header.
- Sits between the cluster combinational block and the regression host; one test vector per accepted handshake.

Parameters:
OUT_W, 128, number of cluster output bits checked per test
CNT_W, 20, width of test and mismatch counters (covers 1000000 tests)
IDX_W, 7, width of bit-index fields; must satisfy 2^IDX_W >= OUT_W

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run, clears counters
num_tests  input  CNT_W  tests in the run; sampled on start
in_valid  input  1  dut_bits/gold_bits valid this cycle
in_ready  output  1  checker accepts a test this cycle
dut_bits  input  OUT_W  outputs of cluster logic
gold_bits  input  OUT_W  expected outputs
test_cnt  output  CNT_W  tests accepted in current run
err_cnt  output  CNT_W  tests with at least one bit mismatch
busy  output  1  high in RUN
done  output  1  high in DONE until next start
pass  output  1  done and err_cnt==0

Behaviour:
- Reset: the FSM enters IDLE. All outputs are 0, including the counters, in_ready, busy, done and pass. Reset is asynchronous and may be asserted mid-run; the partial run is discarded.
- States and transitions:
  - IDLE: leaves on start.
  - start with num_tests==0: goes to DONE next cycle with counters 0 and pass=1.
  - start with num_tests>0: goes to RUN; test_cnt and err_cnt clear to 0 in that cycle.
  - RUN: in_ready=1 and busy=1. A test is accepted when in_valid && in_ready.
  - RUN exit: after the acceptance that makes test_cnt==num_tests, the next state is DONE. in_ready drops in the same cycle the final count registers.
  - DONE: done=1, in_ready=0, counters hold. start re-enters RUN or DONE under the same rules.
  - start while in RUN: ignored.
  - in_valid outside RUN: ignored; the checker drops the data and does not stall.
- Compare pipeline, two stages:
  - Stage 1 registers diff = dut_bits ^ gold_bits on acceptance and increments test_cnt in the same edge.
  - Stage 2 ORs the registered diff and increments err_cnt one cycle later.
  - done asserts only after stage 2 has drained. The last acceptance reaches DONE with err_cnt final, 2 cycles after the handshake.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- X on dut_bits counts as a mismatch in simulation; there is no synthesis impact.
- pass = done && (err_cnt==0), combinational from registers.

Optional Feature:
- Macro MISMATCH_LOG_EN.
- When defined, adds these outputs:
  - first_err_test [CNT_W]: test_cnt value (1-based) of the first failing test.
  - first_err_bit [IDX_W]: lowest set index of that test's diff.
  - err_bit_seen [OUT_W]: sticky OR of all diffs in the run.
- These outputs clear on start and are 0 from reset. first_err_* latch only once per run. With no failure, first_err_test=0.
- When not defined, these ports and registers are absent, and the remaining behaviour is identical.

Test Plan:
- Reset mid-run:
  - Stimulus: num_tests=10; assert rst_n low after 4 accepted tests.
  - Required response: all outputs 0, FSM in IDLE.
  - Then: start with num_tests=3 gives test_cnt=3 and done=1 from a fresh run.
- All-match run:
  - Stimulus: num_tests=5, dut_bits==gold_bits for every test, in_valid held high.
  - Required response: in_ready high exactly 5 cycles; done 2 cycles after the 5th handshake; test_cnt=5, err_cnt=0, pass=1.
- Mismatches with bubbles:
  - Stimulus: num_tests=4 with gaps in in_valid; test 2 flips bit 76, test 4 flips bits 0 and OUT_W-1.
  - Required response: err_cnt=2, pass=0.
  - With MISMATCH_LOG_EN: first_err_test=2, first_err_bit=76, err_bit_seen has bits 0, 76 and OUT_W-1 set.
- Zero-length run and ignored inputs:
  - Stimulus: start with num_tests=0.
  - Required response: done and pass the next cycle; in_ready never rises.
  - Stimulus: in_valid pulsed while in IDLE or DONE.
  - Required response: counters unchanged.
- Saturation:
  - Stimulus: force CNT_W=4, num_tests=15, every test mismatching, then a further start.
  - Required response: err_cnt=15, no wrap.
  - start asserted during RUN has no effect; restart from DONE clears the counters to 0.

Source files
------------

// File: rtl/cluster_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : cluster_result_checker
// Description : Compares the per-bit cluster logic outputs against golden
//               reference bits, one test per accepted handshake. It counts the
//               tests accepted and the tests with at least one differing bit.
//               These counts give the accuracy figures for a generated circuit.
//
//               Ports
//                 clk, rst_n        clock, asynchronous active-low reset
//                 start, num_tests  begin a run of num_tests tests
//                 in_valid/in_ready test handshake (one test per transfer)
//                 dut_bits          cluster logic outputs
//                 gold_bits         reference model outputs
//                 test_cnt, err_cnt accepted tests / failing tests (saturating)
//                 busy, done, pass  run status
//
//               Optional build macro MISMATCH_LOG_EN adds first_err_test,
//               first_err_bit and err_bit_seen for mismatch diagnosis.
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_result_checker #(
    parameter int OUT_W = 128,
    parameter int CNT_W = 20,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tests,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] dut_bits,
    input  logic [OUT_W-1:0] gold_bits,
    output logic [CNT_W-1:0] test_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
`ifdef MISMATCH_LOG_EN
    ,
    output logic [CNT_W-1:0] first_err_test,
    output logic [IDX_W-1:0] first_err_bit,
    output logic [OUT_W-1:0] err_bit_seen
`endif
);

    // DRAIN covers the cycle in which the last diff is still in stage 2.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_test_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [OUT_W-1:0] r_diff;
    logic             r_diff_vld;

    logic             w_start_ok;
    logic             w_accept;
    logic [CNT_W-1:0] w_test_next;
    logic             w_err_any;
    logic             w_err_hit;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept    = in_valid && (r_state == S_RUN);
    assign w_test_next = (r_test_cnt == c_cnt_max) ? r_test_cnt : r_test_cnt + 1'b1;
    assign w_err_any   = |r_diff;
    // An unknown reduction (X on dut_bits) must count as a failure, so the
    // test is "not definitely zero" rather than "is one".
    assign w_err_hit   = r_diff_vld && (w_err_any !== 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_test_cnt <= '0;
            r_err_cnt  <= '0;
            r_diff     <= '0;
            r_diff_vld <= 1'b0;
        end else begin
            r_diff_vld <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_num      <= num_tests;
                        r_test_cnt <= '0;
                        r_err_cnt  <= '0;
                        r_state    <= (num_tests == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        // Stage 1: capture the difference and count the test.
                        r_diff     <= dut_bits ^ gold_bits;
                        r_diff_vld <= 1'b1;
                        r_test_cnt <= w_test_next;
                        if (w_test_next == r_num) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Stage 2: fold the captured difference into the error count.
            // Never coincides with a counter clear: a run can only restart
            // from IDLE or DONE, where the pipeline is already empty.
            if (w_err_hit && (r_err_cnt != c_cnt_max)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign pass     = done && (r_err_cnt == '0);
    assign test_cnt = r_test_cnt;
    assign err_cnt  = r_err_cnt;

`ifdef MISMATCH_LOG_EN
    logic [CNT_W-1:0] r_diff_idx;
    logic [CNT_W-1:0] r_first_test;
    logic [IDX_W-1:0] r_first_bit;
    logic [OUT_W-1:0] r_seen;
    logic             r_first_lat;
    logic [IDX_W-1:0] w_low_idx;

    // Lowest set index of the captured difference.
    always_comb begin
        w_low_idx = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            if (r_diff[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff_idx   <= '0;
            r_first_test <= '0;
            r_first_bit  <= '0;
            r_seen       <= '0;
            r_first_lat  <= 1'b0;
        end else begin
            // Test number travels alongside its diff into stage 2.
            if (w_accept) begin
                r_diff_idx <= w_test_next;
            end
            if (w_start_ok) begin
                r_first_test <= '0;
                r_first_bit  <= '0;
                r_seen       <= '0;
                r_first_lat  <= 1'b0;
            end else if (r_diff_vld) begin
                r_seen <= r_seen | r_diff;
                if (w_err_hit && !r_first_lat) begin
                    r_first_test <= r_diff_idx;
                    r_first_bit  <= w_low_idx;
                    r_first_lat  <= 1'b1;
                end
            end
        end
    end

    assign first_err_test = r_first_test;
    assign first_err_bit  = r_first_bit;
    assign err_bit_seen   = r_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_result_checker
// Description : Self-checking bench for cluster_result_checker. Stimulus
//               pushes the expected end-of-run result into a queue and a
//               monitor pops and compares it whenever a run completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cluster_result_checker;

    localparam int OUT_W = 128;
    localparam int CNT_W = 20;
    localparam int IDX_W = 7;

    typedef struct {
        logic [CNT_W-1:0] tc;
        logic [CNT_W-1:0] ec;
        logic             ps;
        logic [CNT_W-1:0] fet;
        logic [IDX_W-1:0] feb;
        logic [OUT_W-1:0] seen;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_tests = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] dut_bits = '0;
    logic [OUT_W-1:0] gold_bits = '0;
    logic [CNT_W-1:0] test_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             busy, done, pass;
`ifdef MISMATCH_LOG_EN
    logic [CNT_W-1:0] first_err_test;
    logic [IDX_W-1:0] first_err_bit;
    logic [OUT_W-1:0] err_bit_seen;
`endif

    // Small instance for counter-saturation checks.
    logic       s_start = 1'b0;
    logic [3:0] s_num = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_dut = '0;
    logic [7:0] s_gold = '0;
    logic [3:0] s_tc, s_ec;
    logic       s_busy, s_done, s_pass;
`ifdef MISMATCH_LOG_EN
    logic [3:0] s_fet;
    logic [2:0] s_feb;
    logic [7:0] s_seen;
`endif

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];
    logic [OUT_W-1:0] tv_dut[$];
    logic [OUT_W-1:0] tv_gold[$];

    always #5 clk = ~clk;

    cluster_result_checker #(.OUT_W(OUT_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_tests (num_tests),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dut_bits  (dut_bits),
        .gold_bits (gold_bits),
        .test_cnt  (test_cnt),
        .err_cnt   (err_cnt),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
`ifdef MISMATCH_LOG_EN
        ,
        .first_err_test (first_err_test),
        .first_err_bit  (first_err_bit),
        .err_bit_seen   (err_bit_seen)
`endif
    );

    cluster_result_checker #(.OUT_W(8), .CNT_W(4), .IDX_W(3)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .num_tests (s_num),
        .in_valid  (s_valid),
        .in_ready  (s_ready),
        .dut_bits  (s_dut),
        .gold_bits (s_gold),
        .test_cnt  (s_tc),
        .err_cnt   (s_ec),
        .busy      (s_busy),
        .done      (s_done),
        .pass      (s_pass)
`ifdef MISMATCH_LOG_EN
        ,
        .first_err_test (s_fet),
        .first_err_bit  (s_feb),
        .err_bit_seen   (s_seen)
`endif
    );

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result of a run straight from the test vector lists.
    function automatic exp_t model(input int n);
        exp_t e;
        logic [OUT_W-1:0] d;
        e = '{default: '0};
        e.tc = CNT_W'(n);
        for (int i = 0; i < n; i++) begin
            d = tv_dut[i] ^ tv_gold[i];
            if (d != '0) begin
                e.ec++;
                if (e.fet == '0) begin
                    e.fet = CNT_W'(i + 1);
                    for (int b = 0; b < OUT_W; b++) begin
                        if (d[b]) begin
                            e.feb = IDX_W'(b);
                            break;
                        end
                    end
                end
                e.seen |= d;
            end
        end
        e.ps = (e.ec == '0);
        return e;
    endfunction

    // Monitor: a result is presented when done rises, or when done is held
    // across a restart into an immediately-complete (zero-length) run.
    logic prev_done = 1'b0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done && (!prev_done || prev_start)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("res_test_cnt", test_cnt, e.tc);
                chk("res_err_cnt", err_cnt, e.ec);
                chk("res_pass", pass, e.ps);
`ifdef MISMATCH_LOG_EN
                chk("res_first_err_test", first_err_test, e.fet);
                chk("res_first_err_bit", first_err_bit, e.feb);
                chk("res_err_bit_seen", err_bit_seen, e.seen);
`endif
            end
        end
        prev_done  = done && rst_n;
        prev_start = start;
    end

    function automatic logic [OUT_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Run n tests from tv_* with in_valid gaps of gap percent.
    task automatic run(input int n, input int gap, input bit poke);
        int i = 0;
        int rdy = 0;
        int guard = 0;
        bit hs;
        exp_q.push_back(model(n));
        @(posedge clk); #1;
        start = 1'b1;
        num_tests = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_clear_test_cnt", test_cnt, '0);
        chk("start_clear_err_cnt", err_cnt, '0);
        if (n == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_pass", pass, 1'b1);
            chk("zero_in_ready", in_ready, 1'b0);
            return;
        end
        while (i < n && guard < 2000) begin
            in_valid = ($urandom_range(99) >= gap);
            dut_bits = in_valid ? tv_dut[i] : rnd128();
            gold_bits = in_valid ? tv_gold[i] : rnd128();
            if (poke && i == n / 2) begin
                start = 1'b1;
                num_tests = 1;
            end
            @(negedge clk);
            if (in_ready) rdy++;
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            num_tests = CNT_W'(n);
            if (hs) i++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 2000) begin
            chk("run_timeout", 1'b1, 1'b0);
            return;
        end
        // One cycle after the last handshake: count final, stage 2 pending.
        chk("last_in_ready_drop", in_ready, 1'b0);
        chk("last_test_cnt", test_cnt, CNT_W'(n));
        chk("last_done_early", done, 1'b0);
        if (gap == 0) chk("in_ready_cycles", rdy, n);
        @(posedge clk); #1;
        chk("done_latency", done, 1'b1);
    endtask

    task automatic fill_random(input int n);
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] d;
        tv_dut.delete();
        tv_gold.delete();
        for (int i = 0; i < n; i++) begin
            g = rnd128();
            d = g;
            if ($urandom_range(1) == 1) begin
                d[$urandom_range(OUT_W - 1)] ^= 1'b1;
                d[$urandom_range(OUT_W - 1)] ^= 1'b1;
                d[$urandom_range(OUT_W - 1)] ^= 1'b1;
            end
            tv_dut.push_back(d);
            tv_gold.push_back(g);
        end
    endtask

    initial begin
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] d;
        logic [CNT_W-1:0] hold_tc;
        logic [CNT_W-1:0] hold_ec;
        int guard;

        #1;
        chk("reset_test_cnt", test_cnt, '0);
        chk("reset_err_cnt", err_cnt, '0);
        chk("reset_flags", {in_ready, busy, done, pass}, 4'b0);
        @(negedge clk); rst_n = 1'b1;

        // in_valid while IDLE is dropped.
        @(posedge clk); #1;
        in_valid = 1'b1; dut_bits = rnd128(); gold_bits = ~dut_bits;
        repeat (3) @(posedge clk);
        #1; in_valid = 1'b0;
        chk("idle_ignore_test_cnt", test_cnt, '0);
        chk("idle_ignore_err_cnt", err_cnt, '0);

        // Reset mid-run after 4 acceptances.
        start = 1'b1; num_tests = 10;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; dut_bits = rnd128(); gold_bits = rnd128();
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midrun_test_cnt", test_cnt, 4);
        rst_n = 1'b0;
        #2;
        chk("midrun_reset_cnts", {test_cnt, err_cnt}, '0);
        chk("midrun_reset_flags", {in_ready, busy, done, pass}, 4'b0);
        @(negedge clk); rst_n = 1'b1;
        fill_random(3);
        run(3, 20, 1'b0);

        // All-match run, in_valid held high.
        tv_dut.delete(); tv_gold.delete();
        for (int i = 0; i < 5; i++) begin
            g = rnd128();
            tv_dut.push_back(g);
            tv_gold.push_back(g);
        end
        run(5, 0, 1'b0);
        chk("allmatch_pass", pass, 1'b1);

        // Mismatches with bubbles: test 2 bit 76, test 4 bits 0 and OUT_W-1.
        tv_dut.delete(); tv_gold.delete();
        for (int i = 0; i < 4; i++) begin
            g = rnd128();
            d = g;
            if (i == 1) d[76] = ~d[76];
            if (i == 3) begin
                d[0] = ~d[0];
                d[OUT_W-1] = ~d[OUT_W-1];
            end
            tv_dut.push_back(d);
            tv_gold.push_back(g);
        end
        run(4, 50, 1'b0);
        chk("bubbles_err_cnt", err_cnt, 2);
        chk("bubbles_pass", pass, 1'b0);
`ifdef MISMATCH_LOG_EN
        chk("bubbles_first_test", first_err_test, 2);
        chk("bubbles_first_bit", first_err_bit, 76);
        chk("bubbles_seen_bits", {err_bit_seen[OUT_W-1], err_bit_seen[76], err_bit_seen[0]}, 3'b111);
`endif

        // in_valid in DONE is dropped.
        hold_tc = test_cnt;
        hold_ec = err_cnt;
        in_valid = 1'b1; dut_bits = rnd128(); gold_bits = ~dut_bits;
        repeat (3) @(posedge clk);
        #1; in_valid = 1'b0;
        chk("done_ignore_test_cnt", test_cnt, hold_tc);
        chk("done_ignore_err_cnt", err_cnt, hold_ec);

        // Zero-length run from DONE; in_ready must stay low.
        run(0, 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_in_ready_hold", in_ready, 1'b0);
        end

        // Random runs, one with a start pulse during RUN.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(12, 1);
            fill_random(n);
            run(n, $urandom_range(50), r == 2);
        end

        // Saturation-width instance: 15 failing tests, start poked mid-run.
        @(posedge clk); #1;
        s_start = 1'b1; s_num = 15;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_valid = 1'b1;
        guard = 0;
        while (!s_done && guard < 100) begin
            s_gold = 8'($urandom);
            s_dut = s_gold ^ (8'd1 << $urandom_range(7));
            s_start = (guard == 7);
            s_num = (guard == 7) ? 4'd1 : 4'd15;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        s_start = 1'b0;
        chk("sat_timeout", guard < 100, 1'b1);
        chk("sat_test_cnt", s_tc, 15);
        chk("sat_err_cnt", s_ec, 15);
        chk("sat_pass", s_pass, 1'b0);
        s_start = 1'b1; s_num = 2;
        @(posedge clk); #1;
        s_start = 1'b0;
        chk("sat_restart_clear", {s_tc, s_ec}, 8'h00);
        chk("sat_restart_busy", s_busy, 1'b1);

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
